// File: rtl/bus_requester_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_requester_if
//  Description : Requester-side bus signals: request/grant toward the arbiter
//                and the beat handshake toward the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_requester_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              bus_req;
   logic              bus_gnt;
   logic              bus_valid;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   // Requester side
   modport master (
      output bus_req, bus_valid, bus_we, bus_addr, bus_wdata,
      input  bus_gnt, bus_rdata, bus_ack
   );

   // Arbiter + slave side
   modport slave (
      input  bus_req, bus_valid, bus_we, bus_addr, bus_wdata,
      output bus_gnt, bus_rdata, bus_ack
   );
endinterface
`default_nettype wire

// File: rtl/bus_requester.sv
`default_nettype none
// ============================================================================
//  Module      : bus_requester
//  Description : Initiator agent for a priority-arbitrated bus. Accepts a
//                burst command, requests the bus, runs len+1 acked beats,
//                releases the request and pulses done (err on grant timeout
//                or grant loss mid-burst).
//  Revision    : 1.0  initial release
// ============================================================================
module bus_requester #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  wire logic              clk_i,
   input  wire logic              reset_i,
   // local command side
   input  wire logic              cmd_valid_i,
   output      logic              cmd_ready_o,
   input  wire logic              cmd_write_i,
   input  wire logic [ADDR_W-1:0] cmd_addr_i,
   input  wire logic [LEN_W-1:0]  cmd_len_i,
   input  wire logic [DATA_W-1:0] wr_data_i,
   output      logic              wr_pop_o,
   output      logic [DATA_W-1:0] rd_data_o,
   output      logic              rd_valid_o,
   output      logic              done_o,
   output      logic              err_o,
   // arbiter / slave side
   bus_requester_if.master        bus
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_REL  = 2'd3
   } state_t;

   state_t            state_q;
   logic              bus_req_q;
   logic              bus_we_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  beat_q;
   logic [WAIT_W-1:0] wait_q;
   logic              wr_pop_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              done_q;
   logic              err_q;

   // Command/transfer FSM; every output except cmd_ready/bus_valid/bus_wdata is registered here
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         bus_req_q  <= 1'b0;
         bus_we_q   <= 1'b0;
         bus_addr_q <= '0;
         base_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         wait_q     <= '0;
         wr_pop_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_pop_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  bus_we_q  <= cmd_write_i;
                  base_q    <= cmd_addr_i;
                  len_q     <= cmd_len_i;
                  err_q     <= 1'b0;
                  bus_req_q <= 1'b1;
                  wait_q    <= '0;
                  state_q   <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.bus_gnt) begin
                  beat_q     <= '0;
                  bus_addr_q <= base_q;
                  state_q    <= S_XFER;
               end else if (wait_q == WAIT_LAST) begin
                  // grant never arrived: give up the request and report error
                  bus_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= S_REL;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_XFER: begin
               if (bus.bus_ack) begin
                  if (bus_we_q) begin
                     wr_pop_q <= 1'b1;
                  end else begin
                     rd_valid_q <= 1'b1;
                     rd_data_q  <= bus.bus_rdata;
                  end
                  bus_addr_q <= bus_addr_q + 1'b1;
               end
               // grant loss wins over normal completion; an ack in the same cycle still counts
               if (!bus.bus_gnt) begin
                  bus_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= S_REL;
               end else if (bus.bus_ack) begin
                  if (beat_q == len_q) begin
                     bus_req_q <= 1'b0;
                     state_q   <= S_REL;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            S_REL: begin
               // hold off until the arbiter has dropped its grant
               if (!bus.bus_gnt) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o   = (state_q == S_IDLE);
   assign bus.bus_valid = (state_q == S_XFER);
   assign bus.bus_wdata = ((state_q == S_XFER) && bus_we_q) ? wr_data_i : '0;
   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign wr_pop_o      = wr_pop_q;
   assign rd_valid_o    = rd_valid_q;
   assign rd_data_o     = rd_data_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_requester
//  Description : Self-checking bench for bus_requester: cycle vector table
//                for write/read bursts, hand sequences for timeout, grant
//                loss, async reset, and a two-requester arbitration run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_requester;

   logic       clk;
   logic       reset;
   logic       cmd_valid, cmd_write;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic [7:0] wr_data;
   logic       cmd_ready, wr_pop, rd_valid, done, err;
   logic [7:0] rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   bus_requester_if #(.ADDR_W(8), .DATA_W(8)) if_m ();

   bus_requester #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .TIMEOUT(16)) dut (
      .clk_i(clk), .reset_i(reset),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .wr_data_i(wr_data),
      .wr_pop_o(wr_pop), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
      .done_o(done), .err_o(err), .bus(if_m.master)
   );

   // ---------------- two requesters behind a small priority arbiter ----------
   logic       a_cv, b_cv, a_rdy, b_rdy, a_pop, b_pop, a_rv, b_rv, a_done, b_done, a_err, b_err;
   logic [7:0] a_rd, b_rd;
   logic [1:0] arb_g;

   bus_requester_if #(.ADDR_W(8), .DATA_W(8)) if_a ();
   bus_requester_if #(.ADDR_W(8), .DATA_W(8)) if_b ();

   bus_requester #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .TIMEOUT(64)) u_a (
      .clk_i(clk), .reset_i(reset),
      .cmd_valid_i(a_cv), .cmd_ready_o(a_rdy), .cmd_write_i(1'b1),
      .cmd_addr_i(8'h60), .cmd_len_i(4'd3), .wr_data_i(8'hAA),
      .wr_pop_o(a_pop), .rd_data_o(a_rd), .rd_valid_o(a_rv),
      .done_o(a_done), .err_o(a_err), .bus(if_a.master)
   );

   bus_requester #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .TIMEOUT(64)) u_b (
      .clk_i(clk), .reset_i(reset),
      .cmd_valid_i(b_cv), .cmd_ready_o(b_rdy), .cmd_write_i(1'b1),
      .cmd_addr_i(8'h80), .cmd_len_i(4'd1), .wr_data_i(8'hBB),
      .wr_pop_o(b_pop), .rd_data_o(b_rd), .rd_valid_o(b_rv),
      .done_o(b_done), .err_o(b_err), .bus(if_b.master)
   );

   // arbiter: registers requests, lower index wins, holds grant while request stays high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arb_g <= 2'b00;
      end else if (arb_g == 2'b00) begin
         if (if_a.bus_req)      arb_g <= 2'b01;
         else if (if_b.bus_req) arb_g <= 2'b10;
      end else if ((arb_g & {if_b.bus_req, if_a.bus_req}) == 2'b00) begin
         arb_g <= 2'b00;
      end
   end

   assign if_a.bus_gnt   = arb_g[0];
   assign if_b.bus_gnt   = arb_g[1];
   assign if_a.bus_ack   = if_a.bus_valid;
   assign if_b.bus_ack   = if_b.bus_valid;
   assign if_a.bus_rdata = 8'h00;
   assign if_b.bus_rdata = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector table ---------------------------------------------
   typedef struct {
      logic       cv, cw;
      logic [7:0] caddr;
      logic [3:0] clen;
      logic [7:0] wd;
      logic       gnt, ack;
      logic [7:0] rdat;
      logic [30:0] exp;
   } vec_t;

   vec_t vecs[$];

   // expected = {rdy, req, valid, addr, wdata, pop, rdv, rd_data, done, err}
   task automatic add_row(input logic cv, input logic cw, input logic [7:0] caddr, input logic [3:0] clen,
                          input logic [7:0] wd, input logic gnt, input logic ack, input logic [7:0] rdat,
                          input logic rdy, input logic req, input logic vld, input logic [7:0] addr,
                          input logic [7:0] wdat, input logic pop, input logic rdv, input logic [7:0] rdd,
                          input logic dn, input logic er);
      vec_t v;
      v.cv = cv; v.cw = cw; v.caddr = caddr; v.clen = clen; v.wd = wd;
      v.gnt = gnt; v.ack = ack; v.rdat = rdat;
      v.exp = {rdy, req, vld, addr, wdat, pop, rdv, rdd, dn, er};
      vecs.push_back(v);
   endtask

   function automatic logic [30:0] snap();
      return {cmd_ready, if_m.bus_req, if_m.bus_valid, if_m.bus_addr, if_m.bus_wdata,
              wr_pop, rd_valid, rd_data, done, err};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin : main
      int pops;
      int cnt;
      logic saw_valid;
      int cyc, a_done_cyc, b_done_cyc, a_pops, b_pops, overlap;
      logic a_seen, b_seen, a_e, b_e;

      reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
      if_m.bus_gnt = 1'b0; if_m.bus_ack = 1'b0; if_m.bus_rdata = '0;
      a_cv = 1'b0; b_cv = 1'b0;
      step(); step();
      chk("reset_state", {snap(), if_m.bus_we}, {1'b1, 30'h0, 1'b0});
      reset = 1'b0;
      step();

      // write 0x10 len 3, grant after 2 cycles, ack every cycle; acks outside XFER ignored
      add_row(1,1,8'h10,3,8'hC3, 0,0,8'h00, 0,1,0,8'h00,8'h00,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 0,1,8'h77, 0,1,0,8'h00,8'h00,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 1,0,8'h00, 0,1,1,8'h10,8'hC3,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 1,1,8'h00, 0,1,1,8'h11,8'hC3,1,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 1,1,8'h00, 0,1,1,8'h12,8'hC3,1,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 1,1,8'h00, 0,1,1,8'h13,8'hC3,1,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 1,1,8'h00, 0,0,0,8'h14,8'h00,1,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 1,0,8'h00, 0,0,0,8'h14,8'h00,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'hC3, 0,0,8'h00, 1,0,0,8'h14,8'h00,0,0,8'h00,1,0);
      add_row(0,0,8'h00,0,8'hC3, 0,1,8'h77, 1,0,0,8'h14,8'h00,0,0,8'h00,0,0);
      // read 0xFE len 2, ack every other cycle, wraps to 0x00
      add_row(1,0,8'hFE,2,8'h00, 0,0,8'h00, 0,1,0,8'h14,8'h00,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,0,8'h00, 0,1,1,8'hFE,8'h00,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,0,8'hEE, 0,1,1,8'hFE,8'h00,0,0,8'h00,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,1,8'hA0, 0,1,1,8'hFF,8'h00,0,1,8'hA0,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,0,8'hEE, 0,1,1,8'hFF,8'h00,0,0,8'hA0,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,1,8'hA1, 0,1,1,8'h00,8'h00,0,1,8'hA1,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,0,8'hEE, 0,1,1,8'h00,8'h00,0,0,8'hA1,0,0);
      add_row(0,0,8'h00,0,8'h00, 1,1,8'hA2, 0,0,0,8'h01,8'h00,0,1,8'hA2,0,0);
      add_row(0,0,8'h00,0,8'h00, 0,0,8'h00, 1,0,0,8'h01,8'h00,0,0,8'hA2,1,0);

      for (int i = 0; i < vecs.size(); i++) begin
         cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw; cmd_addr = vecs[i].caddr;
         cmd_len = vecs[i].clen; wr_data = vecs[i].wd;
         if_m.bus_gnt = vecs[i].gnt; if_m.bus_ack = vecs[i].ack; if_m.bus_rdata = vecs[i].rdat;
         step();
         chk($sformatf("vec%0d", i), snap(), vecs[i].exp);
      end
      cmd_valid = 1'b0; if_m.bus_gnt = 1'b0; if_m.bus_ack = 1'b0; wr_data = 8'h5D;

      // grant never comes: request held exactly TIMEOUT cycles
      issue(1'b0, 8'h20, 4'd0);
      cnt = 0; saw_valid = 1'b0;
      while (if_m.bus_req && cnt < 100) begin
         cnt++;
         if (if_m.bus_valid) saw_valid = 1'b1;
         step();
      end
      chk("timeout_req_cycles", cnt, 16);
      chk("timeout_no_valid", saw_valid, 1'b0);
      chk("timeout_abort", {done, err}, 2'b01);
      step();
      chk("timeout_done", {done, err, cmd_ready}, 3'b111);
      step();
      chk("timeout_err_held", {done, err}, 2'b01);

      // grant dropped after the first beat of a 4-beat write
      pops = 0;
      issue(1'b1, 8'h30, 4'd3);
      chk("abort_err_cleared", {err, if_m.bus_req}, 2'b01);
      if_m.bus_gnt = 1'b1;
      step(); pops += int'(wr_pop);
      chk("abort_xfer", {if_m.bus_valid, if_m.bus_addr}, {1'b1, 8'h30});
      if_m.bus_ack = 1'b1;
      step(); pops += int'(wr_pop);
      if_m.bus_gnt = 1'b0; if_m.bus_ack = 1'b0;
      step(); pops += int'(wr_pop);
      chk("abort_rel", {if_m.bus_req, if_m.bus_valid, err, done}, 4'b0010);
      step(); pops += int'(wr_pop);
      chk("abort_done", {done, err}, 2'b11);
      chk("abort_pops", pops, 1);

      // next command after abort: single beat (len=0)
      issue(1'b1, 8'h40, 4'd0);
      chk("single_accept", {err, if_m.bus_req, cmd_ready}, 3'b010);
      if_m.bus_gnt = 1'b1;
      step();
      chk("single_beat", {if_m.bus_valid, if_m.bus_addr, if_m.bus_wdata}, {1'b1, 8'h40, 8'h5D});
      if_m.bus_ack = 1'b1;
      step();
      chk("single_pop", {wr_pop, if_m.bus_req, if_m.bus_valid, if_m.bus_addr}, {3'b100, 8'h41});
      if_m.bus_gnt = 1'b0; if_m.bus_ack = 1'b0;
      step();
      chk("single_done", {done, err}, 2'b10);

      // asynchronous reset between edges during a read burst
      issue(1'b0, 8'h50, 4'd3);
      if_m.bus_gnt = 1'b1;
      step();
      if_m.bus_ack = 1'b1; if_m.bus_rdata = 8'h5A;
      step();
      chk("pre_reset_read", {rd_valid, rd_data, if_m.bus_valid}, {1'b1, 8'h5A, 1'b1});
      if_m.bus_ack = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("async_reset_outs", {if_m.bus_req, if_m.bus_valid, if_m.bus_we, if_m.bus_addr, wr_pop,
                               rd_valid, rd_data, done, err}, 22'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      if_m.bus_gnt = 1'b0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         cnt += int'(done);
      end
      chk("post_reset_no_done", cnt, 0);
      chk("post_reset_ready", {cmd_ready, if_m.bus_req}, 2'b10);

      // two requesters contending through the arbiter
      a_cv = 1'b1; b_cv = 1'b1;
      step();
      a_cv = 1'b0; b_cv = 1'b0;
      cyc = 0; a_done_cyc = 0; b_done_cyc = 0; a_pops = 0; b_pops = 0; overlap = 0;
      a_seen = 1'b0; b_seen = 1'b0; a_e = 1'b1; b_e = 1'b1;
      while (!(a_seen && b_seen) && cyc < 200) begin
         if (if_a.bus_valid && if_b.bus_valid) overlap++;
         a_pops += int'(a_pop);
         b_pops += int'(b_pop);
         if (a_done && !a_seen) begin a_seen = 1'b1; a_done_cyc = cyc; a_e = a_err; end
         if (b_done && !b_seen) begin b_seen = 1'b1; b_done_cyc = cyc; b_e = b_err; end
         cyc++;
         step();
      end
      chk("arb_both_done", {a_seen, b_seen}, 2'b11);
      chk("arb_low_index_first", (a_done_cyc < b_done_cyc), 1'b1);
      chk("arb_errs", {a_e, b_e}, 2'b00);
      chk("arb_pops", {a_pops[7:0], b_pops[7:0]}, {8'd4, 8'd2});
      chk("arb_no_overlap", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
